key_debounce_array: RTL and testbench

//   Parametrised N-channel push-button conditioner. Replaces per-key hand-written debounce logic.
//   Per key: 2-flop synchroniser, configurable debounce window, polarity handling.
//   Per key outputs: debounced level, one-cycle press pulse, one-cycle release pulse,
//   and optional hold-to-auto-repeat pulses.

---
 rtl/key_debounce_array_pkg.sv | 24 ++
 rtl/key_debounce_channel.sv | 132 +++++++++++++
 rtl/key_debounce_array.sv | 47 ++++
 tb/tb_key_debounce_array.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_array_pkg.sv
// Shared widths, parameter-legality helpers and repeat-phase type for the key debounce array.
package key_debounce_array_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StRepeat
    } rep_state_e;

    function automatic int unsigned dbc_width(input int unsigned debounce_cycles);
        return $clog2(debounce_cycles);
    endfunction

    function automatic int unsigned hc_width(input int unsigned delay, input int unsigned period);
        return $clog2(((delay > period) ? delay : period) + 1);
    endfunction

    function automatic bit params_legal(input int unsigned debounce_cycles,
                                        input int unsigned delay,
                                        input int unsigned period);
        return (debounce_cycles >= 2) && (delay >= 1) && (period >= 1);
    endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One key: 2-flop synchroniser, debounce counter, hold/auto-repeat counter and
// registered press/release/repeat strobes.
module key_debounce_channel
    import key_debounce_array_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    input  logic repeat_en,
    output logic key_state,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int unsigned     DbcW       = dbc_width(DEBOUNCE_CYCLES);
    localparam int unsigned     HcW        = hc_width(REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [DbcW-1:0] DbcLast    = DbcW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HcW-1:0]  DelayLast  = HcW'(REPEAT_DELAY - 1);
    localparam logic [HcW-1:0]  PeriodLast = HcW'(REPEAT_PERIOD - 1);

    logic            sync1_q, sync2_q;
    logic            pressed;
    logic [DbcW-1:0] dbc_q, dbc_d;
    logic            key_state_q;
    logic            toggle;
    logic            press_pulse_q, release_pulse_q, repeat_pulse_q;
    logic [HcW-1:0]  hc_q, hc_d;
    logic [HcW-1:0]  hc_target;
    logic            hold_active;
    logic            fire;
    rep_state_e      rep_state_q, rep_state_d;

    // Reset loads the released pin level so a held key is seen as a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= ACTIVE_LOW;
            sync2_q <= ACTIVE_LOW;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
        end
    end

    assign pressed = sync2_q ^ ACTIVE_LOW;

    always_comb begin
        toggle = 1'b0;
        dbc_d  = dbc_q;
        if (pressed == key_state_q) begin
            dbc_d = '0;
        end else if (dbc_q == DbcLast) begin
            toggle = 1'b1;
            dbc_d  = '0;
        end else begin
            dbc_d = dbc_q + DbcW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbc_q           <= '0;
            key_state_q     <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
        end else begin
            dbc_q           <= dbc_d;
            key_state_q     <= key_state_q ^ toggle;
            press_pulse_q   <= toggle & ~key_state_q;
            release_pulse_q <= toggle & key_state_q;
        end
    end

    // A toggle while the key is down is a release, which must kill repeats in that same cycle.
    assign hold_active = key_state_q & repeat_en & ~toggle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_state_q <= StIdle;
        end else begin
            rep_state_q <= rep_state_d;
        end
    end

    always_comb begin
        rep_state_d = rep_state_q;
        if (!hold_active) begin
            rep_state_d = StIdle;
        end else if (fire) begin
            rep_state_d = StRepeat;
        end else if (rep_state_q == StIdle) begin
            rep_state_d = StDelay;
        end
    end

    always_comb begin
        hc_target = DelayLast;
        unique case (rep_state_q)
            StRepeat: hc_target = PeriodLast;
            default:  hc_target = DelayLast;
        endcase
        fire = hold_active && (hc_q == hc_target);
    end

    always_comb begin
        hc_d = '0;
        if (hold_active && !fire) begin
            hc_d = hc_q + HcW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc_q           <= '0;
            repeat_pulse_q <= 1'b0;
        end else begin
            hc_q           <= hc_d;
            repeat_pulse_q <= fire;
        end
    end

    assign key_state     = key_state_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign repeat_pulse  = repeat_pulse_q;

endmodule

// File: rtl/key_debounce_array.sv
// N-channel push-button conditioner: one independent debounce/auto-repeat channel per key pin.
module key_debounce_array
    import key_debounce_array_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    input  logic [NUM_KEYS-1:0] repeat_en,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] repeat_pulse
);

    if (!params_legal(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) begin : g_bad_params
        $error("key_debounce_array: need DEBOUNCE_CYCLES>=2, REPEAT_DELAY>=1, REPEAT_PERIOD>=1");
    end

    if (NUM_KEYS < 1) begin : g_bad_num_keys
        $error("key_debounce_array: NUM_KEYS must be at least 1");
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_channel (
            .clk           (clk),
            .rst_n         (rst_n),
            .key_in        (key_in[i]),
            .repeat_en     (repeat_en[i]),
            .key_state     (key_state[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .repeat_pulse  (repeat_pulse[i])
        );
    end

endmodule

// File: tb/tb_key_debounce_array.sv
// Bench for key_debounce_array: behavioural model feeds an event scoreboard, plus directed latency checks.
module tb_key_debounce_array;

    localparam int unsigned NK   = 3;
    localparam int unsigned DBC  = 8;
    localparam int unsigned RDLY = 20;
    localparam int unsigned RPER = 5;

    typedef struct {
        int             cyc;
        logic [NK-1:0]  press;
        logic [NK-1:0]  rel;
        logic [NK-1:0]  rep;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] key_in;
    logic [NK-1:0] repeat_en;
    logic [NK-1:0] key_state, press_pulse, release_pulse, repeat_pulse;

    int n_pass = 0;
    int n_total = 0;

    key_debounce_array #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DBC),
        .REPEAT_DELAY    (RDLY),
        .REPEAT_PERIOD   (RPER),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_in        (key_in),
        .repeat_en     (repeat_en),
        .key_state     (key_state),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .repeat_pulse  (repeat_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // The debouncer sees the pin two edges late; a level is accepted after DBC consecutive
    // differing samples; repeats fall at arm_edge+RDLY-1, then every RPER edges.
    bit            hist1 [NK];
    bit            hist2 [NK];
    int            run [NK];
    bit            armed [NK];
    int            next_rep [NK];
    logic [NK-1:0] exp_state;
    int            edge_cnt = 0;
    ev_t           sb [$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NK; k++) begin
                hist1[k] = 1'b0; hist2[k] = 1'b0; run[k] = 0; armed[k] = 1'b0; next_rep[k] = 0;
            end
            exp_state = '0;
            sb.delete();
        end else begin
            ev_t ev;
            edge_cnt++;
            ev.cyc = edge_cnt; ev.press = '0; ev.rel = '0; ev.rep = '0;
            for (int k = 0; k < NK; k++) begin
                bit syncp, prev, tog;
                syncp = hist2[k];
                hist2[k] = hist1[k];
                hist1[k] = (key_in[k] == 1'b0);
                prev = exp_state[k];
                tog = 1'b0;
                if (syncp != prev) begin
                    run[k]++;
                    if (run[k] == DBC) begin tog = 1'b1; run[k] = 0; end
                end else begin
                    run[k] = 0;
                end
                exp_state[k] = prev ^ tog;
                if (tog && !prev) ev.press[k] = 1'b1;
                if (tog && prev) ev.rel[k] = 1'b1;
                if (prev && repeat_en[k] && !tog) begin
                    if (!armed[k]) begin
                        armed[k] = 1'b1;
                        next_rep[k] = edge_cnt + RDLY - 1;
                    end
                    if (edge_cnt == next_rep[k]) begin
                        ev.rep[k] = 1'b1;
                        next_rep[k] += RPER;
                    end
                end else begin
                    armed[k] = 1'b0;
                end
            end
            if ((ev.press | ev.rel | ev.rep) != '0) sb.push_back(ev);
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        ev_t ev;
        chk("key_state", {29'd0, key_state}, {29'd0, exp_state});
        while (sb.size() > 0 && sb[0].cyc < edge_cnt) begin
            ev = sb.pop_front();
            chk("missed_event_cycle", edge_cnt, ev.cyc);
        end
        if ((press_pulse | release_pulse | repeat_pulse) != '0 ||
            (sb.size() > 0 && sb[0].cyc == edge_cnt)) begin
            if (sb.size() == 0 || sb[0].cyc != edge_cnt) begin
                chk("unexpected_pulse", {20'd0, press_pulse, release_pulse, repeat_pulse, 3'd0}, 0);
            end else begin
                ev = sb.pop_front();
                chk("press_pulse", {29'd0, press_pulse}, {29'd0, ev.press});
                chk("release_pulse", {29'd0, release_pulse}, {29'd0, ev.rel});
                chk("repeat_pulse", {29'd0, repeat_pulse}, {29'd0, ev.rep});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Edges until the selected strobe on key k; gives up at the budget.
    task automatic edges_until(input int k, input bit rel, input int budget, output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!(rel ? release_pulse[k] : press_pulse[k]) && n < budget);
    endtask

    initial begin
        int n, cnt, first;
        key_in = '1;
        repeat_en = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        key_in[0] = 1'b0;
        rst_n = 1'b1;

        // Clean press from cycle 0: strobe on edge 10 only.
        for (int e = 1; e <= 11; e++) begin
            @(posedge clk);
            #1;
            if (e == 9) chk("t1_edge9", {26'd0, key_state, press_pulse}, 0);
            if (e == 10) chk("t1_edge10", {26'd0, key_state, press_pulse}, {26'd0, 3'b001, 3'b001});
            if (e == 11) chk("t1_edge11", {29'd0, press_pulse}, 0);
        end

        // Short glitch, then bounce, then a settled press.
        key_in[1] = 1'b0;
        step(7);
        key_in[1] = 1'b1;
        step(20);
        chk("t2_glitch_ignored", {31'd0, key_state[1]}, 0);
        for (int i = 0; i < 10; i++) begin
            key_in[1] = ~key_in[1];
            step(3);
        end
        key_in[1] = 1'b0;
        edges_until(1, 1'b0, 40, n);
        chk("t2_press_latency", n, 10);
        step(5);

        // Release key 0.
        key_in[0] = 1'b1;
        edges_until(0, 1'b1, 40, n);
        chk("t3_release_latency", n, 10);
        chk("t3_state_low", {31'd0, key_state[0]}, 0);
        step(5);

        // Auto-repeat enabled on key 2.
        repeat_en[2] = 1'b1;
        key_in[2] = 1'b0;
        edges_until(2, 1'b0, 40, n);
        chk("t4_press_latency", n, 10);
        cnt = 0; first = 0;
        for (int e = 1; e <= 60; e++) begin
            step(1);
            if (repeat_pulse[2]) begin
                cnt++;
                if (first == 0) first = e;
            end
        end
        chk("t4_repeat_count", cnt, 9);
        chk("t4_repeat_first", first, RDLY);
        key_in[2] = 1'b1;
        key_in[1] = 1'b1;
        edges_until(2, 1'b1, 40, n);
        chk("t4_release_latency", n, 10);
        step(5);

        // Same hold with repeat disabled.
        repeat_en[2] = 1'b0;
        key_in[2] = 1'b0;
        edges_until(2, 1'b0, 40, n);
        cnt = 0;
        for (int e = 1; e <= 60; e++) begin
            step(1);
            if (repeat_pulse[2]) cnt++;
        end
        chk("t4_no_repeat", cnt, 0);
        key_in[2] = 1'b1;
        edges_until(2, 1'b1, 40, n);
        step(5);

        // Simultaneous press and release.
        key_in = 3'b000;
        edges_until(0, 1'b0, 40, n);
        chk("t5_press_all", {29'd0, press_pulse}, {29'd0, 3'b111});
        step(5);
        key_in = 3'b111;
        edges_until(0, 1'b1, 40, n);
        chk("t5_release_all", {29'd0, release_pulse}, {29'd0, 3'b111});
        step(5);

        // Reset mid-debounce with key still held.
        key_in[0] = 1'b0;
        step(7);
        rst_n = 1'b0;
        #1;
        chk("t6_reset_outputs", {20'd0, key_state, press_pulse, release_pulse, repeat_pulse}, 0);
        step(3);
        chk("t6_reset_hold", {20'd0, key_state, press_pulse, release_pulse, repeat_pulse}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        edges_until(0, 1'b0, 40, n);
        chk("t6_press_after_reset", n, 10);
        step(5);

        // Randomised traffic: bouncy phase, then long holds with enable toggling.
        for (int c = 0; c < 4000; c++) begin
            int div;
            div = (c < 2000) ? 11 : 60;
            for (int k = 0; k < NK; k++) begin
                if ($urandom_range(0, div) == 0) key_in[k] = ~key_in[k];
                if ($urandom_range(0, 80) == 0) repeat_en[k] = ~repeat_en[k];
            end
            step(1);
        end
        key_in = '1;
        step(40);
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
